// File: rtl/vp_charset_arbiter_pkg.sv
// Shared constants for the charset RAM arbiter: default latency, colour/bitmap widths,
// FSM encodings and a small saturating-increment helper.
package vp_charset_arbiter_pkg;

    localparam int unsigned RamLatencyDefault = 2;
    localparam int unsigned ColourWidth       = 4;
    localparam int unsigned BitmapWidth       = 16;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StGuard = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vp_fetch_tag_pipe.sv
// Carries {valid, foreground, background, enabled} alongside a charset fetch so the
// colours leave aligned with the registered bitmap.
module vp_fetch_tag_pipe
    import vp_charset_arbiter_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = RamLatencyDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic [ColourWidth-1:0] fg_i,
    input  logic [ColourWidth-1:0] bg_i,
    input  logic                   en_i,
    output logic                   tap_valid_o,
    output logic                   valid_o,
    output logic [ColourWidth-1:0] fg_o,
    output logic [ColourWidth-1:0] bg_o,
    output logic                   en_o
);

    localparam int unsigned Depth = RAM_LATENCY + 1;

    logic [Depth-1:0]                  valid_q;
    logic [Depth-1:0][ColourWidth-1:0] fg_q;
    logic [Depth-1:0][ColourWidth-1:0] bg_q;
    logic [Depth-1:0]                  en_q;

    // Payload only advances behind a valid entry, so the last stage keeps the
    // most recent fetch's colours during idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            en_q    <= '0;
        end else begin
            valid_q <= {valid_q[Depth-2:0], valid_i};
            if (valid_i) begin
                fg_q[0] <= fg_i;
                bg_q[0] <= bg_i;
                en_q[0] <= en_i;
            end
            for (int i = 1; i < Depth; i++) begin
                if (valid_q[i-1]) begin
                    fg_q[i] <= fg_q[i-1];
                    bg_q[i] <= bg_q[i-1];
                    en_q[i] <= en_q[i-1];
                end
            end
        end
    end

    // Stage RAM_LATENCY-1 is live in the cycle the RAM presents this fetch's data.
    assign tap_valid_o = valid_q[Depth-2];
    assign valid_o     = valid_q[Depth-1];
    assign fg_o        = fg_q[Depth-1];
    assign bg_o        = bg_q[Depth-1];
    assign en_o        = en_q[Depth-1];

endmodule

// File: rtl/vp_charset_arbiter.sv
// Single-port charset RAM arbiter: video fetches win every cycle with fixed latency,
// writer updates fill the gaps via valid/ready with starvation monitoring.
module vp_charset_arbiter
    import vp_charset_arbiter_pkg::*;
#(
    parameter int unsigned RAM_LATENCY  = RamLatencyDefault,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vid_req,
    input  logic [ADDR_WIDTH-1:0]  vid_address,
    input  logic [ColourWidth-1:0] vid_foreground,
    input  logic [ColourWidth-1:0] vid_background,
    input  logic                   vid_enabled,
    input  logic                   blanking,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_WIDTH-1:0]  wr_address,
    input  logic [BitmapWidth-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic                   ram_write,
    output logic [BitmapWidth-1:0] ram_wdata,
    input  logic [BitmapWidth-1:0] ram_rdata,
    output logic [ColourWidth-1:0] foreground,
    output logic [ColourWidth-1:0] background,
    output logic [BitmapWidth-1:0] bitmap,
    output logic                   enabled,
    output logic                   bitmap_valid,
    output logic                   wr_starved,
    output logic [15:0]            wr_count
);

    localparam logic [2:0] GuardLast = 3'(RAM_LATENCY - 1);

    logic [1:0]             state_q, state_d;
    logic [2:0]             guard_cnt_q, guard_cnt_d;
    logic                   blank_q;
    logic                   pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [7:0]             starve_q, starve_d;
    logic                   starved_q;
    logic [15:0]            count_q;
    logic [BitmapWidth-1:0] bitmap_q;

    logic vid_grant, wr_accept, blank_fall, enter_guard;
    logic tap_valid, pipe_valid, pipe_en;

    // Gated by reset_n so the RAM port is quiet while reset is held.
    always_comb begin
        vid_grant   = reset_n & vid_req;
        wr_accept   = reset_n & ~vid_req & (state_q != StGuard) & wr_valid;
        ram_address = addr_q;
        if (vid_grant) begin
            ram_address = vid_address;
        end else if (wr_accept) begin
            ram_address = wr_address;
        end
        ram_write = wr_accept;
        ram_wdata = wr_accept ? wr_data : '0;
        wr_ready  = wr_accept;
    end

    always_comb begin
        blank_fall  = blank_q & ~blanking;
        enter_guard = vid_req & ~blanking & (pend_q | blank_fall);
        pend_d      = pend_q;
        if (blanking) begin
            pend_d = 1'b0;
        end else if (blank_fall) begin
            pend_d = 1'b1;
        end
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        case (state_q)
            StGuard: begin
                if (guard_cnt_q == GuardLast) begin
                    state_d = StIdle;
                end else begin
                    guard_cnt_d = guard_cnt_q + 3'd1;
                end
            end
            default: begin
                if (enter_guard) begin
                    state_d     = StGuard;
                    guard_cnt_d = '0;
                    pend_d      = 1'b0;
                end else begin
                    state_d = wr_accept ? StWrite : StIdle;
                end
            end
        endcase

        starve_d = (wr_valid & ~wr_accept) ? sat_inc8(starve_q) : 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            guard_cnt_q <= '0;
            blank_q     <= 1'b0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            starve_q    <= '0;
            starved_q   <= 1'b0;
            count_q     <= '0;
            bitmap_q    <= '0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            blank_q     <= blanking;
            pend_q      <= pend_d;
            addr_q      <= ram_address;
            starve_q    <= starve_d;
            starved_q   <= ({24'd0, starve_d} >= STARVE_LIMIT);
            if (wr_accept) begin
                count_q <= count_q + 16'd1;
            end
            if (tap_valid) begin
                bitmap_q <= ram_rdata;
            end
        end
    end

    vp_fetch_tag_pipe #(
        .RAM_LATENCY (RAM_LATENCY)
    ) u_tag_pipe (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .valid_i     (vid_grant),
        .fg_i        (vid_foreground),
        .bg_i        (vid_background),
        .en_i        (vid_enabled),
        .tap_valid_o (tap_valid),
        .valid_o     (pipe_valid),
        .fg_o        (foreground),
        .bg_o        (background),
        .en_o        (pipe_en)
    );

    assign bitmap       = bitmap_q;
    assign bitmap_valid = pipe_valid;
    assign enabled      = pipe_valid & pipe_en;
    assign wr_starved   = starved_q;
    assign wr_count     = count_q;

endmodule

// File: tb/tb_vp_charset_arbiter.sv
// Randomized bench for vp_charset_arbiter with a cycle-level reference model of
// arbitration, fetch latency, guard window, starvation and write counting.
module tb_vp_charset_arbiter;

    localparam int L  = 2;
    localparam int AW = 14;
    localparam int SL = 255;

    logic          clk, reset_n;
    logic          vid_req, vid_enabled, blanking, wr_valid, wr_ready;
    logic [AW-1:0] vid_address, wr_address, ram_address;
    logic [3:0]    vid_foreground, vid_background, foreground, background;
    logic [15:0]   wr_data, ram_wdata, ram_rdata, bitmap, wr_count;
    logic          ram_write, enabled, bitmap_valid, wr_starved;

    vp_charset_arbiter #(
        .RAM_LATENCY  (L),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vid_req        (vid_req),
        .vid_address    (vid_address),
        .vid_foreground (vid_foreground),
        .vid_background (vid_background),
        .vid_enabled    (vid_enabled),
        .blanking       (blanking),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .ram_address    (ram_address),
        .ram_write      (ram_write),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .foreground     (foreground),
        .background     (background),
        .bitmap         (bitmap),
        .enabled        (enabled),
        .bitmap_valid   (bitmap_valid),
        .wr_starved     (wr_starved),
        .wr_count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Charset RAM stand-in: read-before-write, data L cycles after the address.
    logic [15:0] ram_mem [1<<AW];
    logic [15:0] rd_pipe [L];
    always @(posedge clk) begin
        rd_pipe[0] <= ram_mem[ram_address];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (ram_write) ram_mem[ram_address] <= ram_wdata;
    end
    assign ram_rdata = rd_pipe[L-1];

    typedef struct packed {
        int          due;
        logic [15:0] data;
        logic [3:0]  fg;
        logic [3:0]  bg;
        logic        en;
    } fetch_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          seen_valid = 0;
    fetch_t      exp_q[$];
    logic [15:0] mem_ref [1<<AW];
    logic [15:0] m_count, hold_bm;
    logic [3:0]  hold_fg, hold_bg;
    logic [AW-1:0] m_addr;
    logic        m_blank, m_pend, m_starved;
    int          m_wait, m_guard;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = '0; hold_bm = '0; hold_fg = '0; hold_bg = '0; m_addr = '0;
        m_blank = 1'b0; m_pend = 1'b0; m_starved = 1'b0; m_wait = 0; m_guard = 0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check port decision, advance model.
    task automatic step(input logic vr, input logic [AW-1:0] va, input logic [3:0] fg,
                        input logic [3:0] bg, input logic en, input logic blk,
                        input logic wv, input logic [AW-1:0] wa, input logic [15:0] wd,
                        output logic acc);
        logic exp_bv, exp_en;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        exp_bv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_en = 1'b0;
        if (exp_bv) begin
            hold_bm = exp_q[0].data;
            hold_fg = exp_q[0].fg;
            hold_bg = exp_q[0].bg;
            exp_en  = exp_q[0].en;
            void'(exp_q.pop_front());
        end
        if (bitmap_valid) seen_valid++;
        check_val("bitmap_valid", 32'(bitmap_valid), 32'(exp_bv));
        check_val("enabled", 32'(enabled), 32'(exp_en));
        check_val("bitmap", 32'(bitmap), 32'(hold_bm));
        check_val("foreground", 32'(foreground), 32'(hold_fg));
        check_val("background", 32'(background), 32'(hold_bg));
        check_val("wr_starved", 32'(wr_starved), 32'(m_starved));
        check_val("wr_count", 32'(wr_count), 32'(m_count));

        vid_req = vr; vid_address = va; vid_foreground = fg; vid_background = bg;
        vid_enabled = en; blanking = blk; wr_valid = wv; wr_address = wa; wr_data = wd;
        #1;
        if (blk) m_pend = 1'b0;
        else if (m_blank) m_pend = 1'b1;
        acc = wv && !vr && (m_guard == 0);
        exp_addr = vr ? va : (acc ? wa : m_addr);
        check_val("wr_ready", 32'(wr_ready), 32'(acc));
        check_val("ram_write", 32'(ram_write), 32'(acc));
        check_val("ram_address", 32'(ram_address), 32'(exp_addr));
        if (acc) check_val("ram_wdata", 32'(ram_wdata), 32'(wd));

        if (vr) exp_q.push_back('{due: cyc + L + 1, data: mem_ref[va], fg: fg, bg: bg, en: en});
        if (acc) begin
            mem_ref[wa] = wd;
            m_count++;
        end
        m_addr = exp_addr;
        m_wait = (wv && !acc) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
        m_starved = (m_wait >= SL);
        if (m_guard > 0) m_guard--;
        else if (m_pend && vr && !blk) begin
            m_guard = L;
            m_pend  = 1'b0;
        end
        m_blank = blk;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        vid_req = 0; wr_valid = 0; blanking = 0;
        #1;
        check_val("rst_bitmap_valid", 32'(bitmap_valid), 0);
        check_val("rst_enabled", 32'(enabled), 0);
        check_val("rst_bitmap", 32'(bitmap), 0);
        check_val("rst_fg", 32'(foreground), 0);
        check_val("rst_bg", 32'(background), 0);
        check_val("rst_wr_ready", 32'(wr_ready), 0);
        check_val("rst_ram_write", 32'(ram_write), 0);
        check_val("rst_ram_address", 32'(ram_address), 0);
        check_val("rst_ram_wdata", 32'(ram_wdata), 0);
        check_val("rst_wr_starved", 32'(wr_starved), 0);
        check_val("rst_wr_count", 32'(wr_count), 0);
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic acc;
        logic [AW-1:0] wq_a[$];
        logic [15:0]   wq_d[$];
        int            g_acc;
        logic          blk, wv_hold;
        logic [AW-1:0] wa_hold;
        logic [15:0]   wd_hold;

        reset_n = 1'b1; vid_req = 0; vid_address = '0; vid_foreground = '0;
        vid_background = '0; vid_enabled = 0; blanking = 0; wr_valid = 0;
        wr_address = '0; wr_data = '0;
        model_reset();
        #3;
        do_reset(2);

        // Prefill the window the bench fetches from, plus the single-fetch word.
        for (int a = 0; a < 64; a++) step(0, '0, 0, 0, 0, 0, 1, AW'(a), 16'($urandom), acc);
        step(0, '0, 0, 0, 0, 0, 1, 14'h0123, 16'hA5F0, acc);
        repeat (3) step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);

        // Single fetch, one pulse L+1 cycles later.
        seen_valid = 0;
        step(1, 14'h0123, 4'd3, 4'd9, 1, 0, 0, '0, '0, acc);
        repeat (L + 3) step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);
        check_val("single_pulses", 32'(seen_valid), 1);
        check_val("single_bitmap_held", 32'(bitmap), 32'h0000A5F0);

        // Reset with three fetches in flight; none may surface afterwards.
        for (int i = 0; i < 3; i++)
            step(1, AW'($urandom_range(0, 63)), 4'($urandom), 4'($urandom), 1, 0, 0, '0, '0, acc);
        do_reset(2);
        seen_valid = 0;
        repeat (L + 4) step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);
        check_val("dropped_pulses", 32'(seen_valid), 0);

        // Contention: writer blocked by continuous video until the first gap.
        for (int i = 0; i < 300; i++)
            step(1, AW'($urandom_range(0, 63)), 4'($urandom), 4'($urandom), 1'($urandom),
                 0, 1, 14'd5, 16'hBEEF, acc);
        check_val("starved_under_contention", 32'(wr_starved), 1);
        step(0, '0, 0, 0, 0, 0, 1, 14'd5, 16'hBEEF, acc);
        check_val("contention_accept", 32'(acc), 1);
        step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);
        check_val("contention_count", 32'(wr_count), 1);
        check_val("starved_cleared", 32'(wr_starved), 0);

        // Interleave: alternate video with four queued writes.
        for (int i = 0; i < 4; i++) begin
            wq_a.push_back(AW'($urandom_range(0, 63)));
            wq_d.push_back(16'($urandom));
        end
        for (int i = 0; i < 14; i++) begin
            if (wq_a.size() > 0)
                step((i % 2) == 0, AW'($urandom_range(0, 63)), 4'($urandom), 4'($urandom),
                     1, 0, 1, wq_a[0], wq_d[0], acc);
            else
                step((i % 2) == 0, AW'($urandom_range(0, 63)), 4'($urandom), 4'($urandom),
                     1, 0, 0, '0, '0, acc);
            if (acc) begin
                void'(wq_a.pop_front());
                void'(wq_d.pop_front());
            end
        end
        check_val("interleave_drained", 32'(wq_a.size()), 0);

        // Guard: blanking falls, video returns, writer is held off for L cycles.
        repeat (4) step(0, '0, 0, 0, 0, 1, 1, 14'd7, 16'h1234, acc);
        step(1, 14'd8, 4'd1, 4'd2, 1, 0, 1, 14'd7, 16'h1234, acc);
        g_acc = 0;
        for (int i = 0; i < L; i++) begin
            step(0, '0, 0, 0, 0, 0, 1, 14'd7, 16'h1234, acc);
            if (acc) g_acc++;
        end
        check_val("guard_blocked", 32'(g_acc), 0);
        step(0, '0, 0, 0, 0, 0, 1, 14'd7, 16'h1234, acc);
        check_val("guard_resume", 32'(acc), 1);

        // Randomized mix with a holding writer and occasional blanking edges.
        blk = 0; wv_hold = 0; wa_hold = '0; wd_hold = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) blk = ~blk;
            if (!wv_hold && $urandom_range(0, 2) == 0) begin
                wv_hold = 1;
                wa_hold = AW'($urandom_range(0, 63));
                wd_hold = 16'($urandom);
            end
            step(1'($urandom), AW'($urandom_range(0, 63)), 4'($urandom), 4'($urandom),
                 1'($urandom), blk, wv_hold, wa_hold, wd_hold, acc);
            if (acc) wv_hold = 0;
        end
        repeat (L + 2) step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);

        // Counter wrap.
        do_reset(2);
        for (int i = 0; i < 65535; i++)
            step(0, '0, 0, 0, 0, 0, 1, AW'($urandom_range(0, 63)), 16'($urandom), acc);
        step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);
        check_val("wrap_ffff", 32'(wr_count), 32'h0000FFFF);
        step(0, '0, 0, 0, 0, 0, 1, 14'd3, 16'hCAFE, acc);
        step(0, '0, 0, 0, 0, 0, 0, '0, '0, acc);
        check_val("wrap_zero", 32'(wr_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
